// File: rtl/pair_collision_scanner.sv
// pair_collision_scanner
//
// Purpose: sequential sprite collision detector. On an accepted start it
// snapshots every sprite position, radius and enable bit. It then walks all
// unordered sprite pairs, one pair per clock, through a two-stage pipeline.
// When the scan ends it publishes a symmetric collision matrix and the number
// of colliding pairs.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   start       scan request, only honoured while idle
//   active      per-sprite enable, captured with the snapshot
//   locations   [SPRITES][DIMENSIONS][WIDTH] signed fixed-point positions
//   radii       [SPRITES][RADIUS_WIDTH] unsigned radii in coordinate units
//   busy        high while a scan is in flight
//   done        one-cycle pulse when collision/pair_count are refreshed
//   collision   [SPRITES][SPRITES] symmetric hit matrix, zero diagonal
//   pair_count  number of colliding unordered pairs
module pair_collision_scanner #(
    parameter int SPRITES      = 9,
    parameter int DIMENSIONS   = 2,
    parameter int WIDTH        = 32,
    parameter int FRAC         = 16,
    parameter int RADIUS_WIDTH = 7
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic [SPRITES-1:0]                             active,
    input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]  locations,
    input  logic [SPRITES-1:0][RADIUS_WIDTH-1:0]           radii,
    output logic                                           busy,
    output logic                                           done,
    output logic [SPRITES-1:0][SPRITES-1:0]                collision,
    output logic [$clog2(SPRITES*(SPRITES-1)/2+1)-1:0]     pair_count
);

    localparam int IW  = $clog2(SPRITES);
    localparam int CW  = $clog2(SPRITES*(SPRITES-1)/2+1);
    localparam int DW  = 2*WIDTH + 2 + $clog2(DIMENSIONS);
    localparam int RSW = 2*RADIUS_WIDTH + 2;
    localparam int KW  = (DW > RSW) ? DW : RSW;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t state, state_next;

    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] snap_loc;
    logic [SPRITES-1:0][RADIUS_WIDTH-1:0]          snap_rad;
    logic [SPRITES-1:0]                            snap_act;

    logic [IW-1:0] pair_i, pair_j;
    logic          start_scan, last_pair, pipe_empty, hit;

    logic                                s1_valid, s1_ok;
    logic [IW-1:0]                       s1_i, s1_j;
    logic [DIMENSIONS-1:0][WIDTH:0]      s1_diff, diff_next;
    logic [RADIUS_WIDTH:0]               s1_rsum, rsum_next;
    logic [WIDTH:0]                      coord_a, coord_b;

    logic                                s2_valid, s2_ok;
    logic [IW-1:0]                       s2_i, s2_j;
    logic [DW-1:0]                       s2_dsq, dsq_next;
    logic [RSW-1:0]                      s2_rsq, rsq_next, rsum_ext;
    logic [2*WIDTH+1:0]                  diff_ext, diff_sq;

    logic [SPRITES-1:0][SPRITES-1:0]     work;
    logic [CW-1:0]                       work_count;

    assign start_scan = (state == IDLE) && start;
    assign last_pair  = (pair_i == IW'(SPRITES-2)) && (pair_j == IW'(SPRITES-1));
    assign pipe_empty = !s1_valid && !s2_valid;
    assign busy       = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = SCAN;
            SCAN:    if (last_pair)  state_next = DRAIN;
            DRAIN:   if (pipe_empty) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Stage 1 inputs: coordinates are sign-extended by one bit so the
    // difference of any two WIDTH-bit values is exact.
    always_comb begin
        diff_next = '0;
        coord_a   = '0;
        coord_b   = '0;
        for (int d = 0; d < DIMENSIONS; d++) begin
            coord_a      = {snap_loc[pair_i][d][WIDTH-1], snap_loc[pair_i][d]};
            coord_b      = {snap_loc[pair_j][d][WIDTH-1], snap_loc[pair_j][d]};
            diff_next[d] = coord_a - coord_b;
        end
        rsum_next = {1'b0, snap_rad[pair_i]} + {1'b0, snap_rad[pair_j]};
    end

    // Stage 2 inputs: squaring the sign-extended difference keeps the low
    // 2*WIDTH+2 bits of the product exact, and the sum grows by clog2(DIMENSIONS)
    // bits so it can never wrap.
    always_comb begin
        dsq_next = '0;
        diff_ext = '0;
        diff_sq  = '0;
        for (int d = 0; d < DIMENSIONS; d++) begin
            diff_ext = {{(WIDTH+1){s1_diff[d][WIDTH]}}, s1_diff[d]};
            diff_sq  = diff_ext * diff_ext;
            dsq_next = dsq_next + DW'(diff_sq);
        end
        rsum_ext = {{(RADIUS_WIDTH+1){1'b0}}, s1_rsum};
        rsq_next = rsum_ext * rsum_ext;
    end

    // Dropping the fractional bits of the squared distance truncates, so a
    // pair is a hit whenever the integer part of the squared distance does not
    // exceed the squared radius sum; exact touching counts as a hit.
    assign hit = s2_valid && s2_ok && (KW'(s2_dsq >> (2*FRAC)) <= KW'(s2_rsq));

    // Control, pair sequencing, working results and published outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            pair_i     <= '0;
            pair_j     <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            work       <= '0;
            work_count <= '0;
            collision  <= '0;
            pair_count <= '0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            s1_valid <= (state == SCAN);
            s2_valid <= s1_valid;

            if (hit) begin
                work[s2_i][s2_j] <= 1'b1;
                work[s2_j][s2_i] <= 1'b1;
                work_count       <= work_count + CW'(1);
            end

            if (start_scan) begin
                pair_i     <= '0;
                pair_j     <= IW'(1);
                work       <= '0;
                work_count <= '0;
            end else if (state == SCAN && !last_pair) begin
                if (pair_j == IW'(SPRITES-1)) begin
                    pair_i <= pair_i + IW'(1);
                    pair_j <= pair_i + IW'(2);
                end else begin
                    pair_j <= pair_j + IW'(1);
                end
            end

            if (state == DRAIN && pipe_empty) begin
                collision  <= work;
                pair_count <= work_count;
                done       <= 1'b1;
            end
        end
    end

    // Snapshot and pipeline data registers; their contents only matter
    // when the matching valid bit is set, so they carry no reset.
    always_ff @(posedge clock) begin
        if (start_scan) begin
            snap_loc <= locations;
            snap_rad <= radii;
            snap_act <= active;
        end
        s1_diff <= diff_next;
        s1_rsum <= rsum_next;
        s1_ok   <= snap_act[pair_i] & snap_act[pair_j];
        s1_i    <= pair_i;
        s1_j    <= pair_j;
        s2_dsq  <= dsq_next;
        s2_rsq  <= rsq_next;
        s2_ok   <= s1_ok;
        s2_i    <= s1_i;
        s2_j    <= s1_j;
    end

endmodule

// File: tb/tb_pair_collision_scanner.sv
// tb_pair_collision_scanner
//
// Purpose: directed bench for pair_collision_scanner. A 3-sprite instance
// covers the geometry cases; a 9-sprite instance covers full-size latency
// and abort by reset.
module tb_pair_collision_scanner;

    logic                        clock;
    logic                        reset3, start3, busy3, done3;
    logic [2:0]                  active3;
    logic [2:0][1:0][31:0]       loc3;
    logic [2:0][6:0]             rad3;
    logic [2:0][2:0]             coll3;
    logic [1:0]                  count3;

    logic                        reset9, start9, busy9, done9;
    logic [8:0]                  active9;
    logic [8:0][1:0][31:0]       loc9;
    logic [8:0][6:0]             rad9;
    logic [8:0][8:0]             coll9;
    logic [5:0]                  count9;

    logic [2:0][2:0]             exp3;
    logic [8:0][8:0]             exp9;

    int vectors     = 0;
    int miscompares = 0;

    pair_collision_scanner #(.SPRITES(3)) dut3 (
        .clock(clock), .reset(reset3), .start(start3), .active(active3),
        .locations(loc3), .radii(rad3), .busy(busy3), .done(done3),
        .collision(coll3), .pair_count(count3)
    );

    pair_collision_scanner #(.SPRITES(9)) dut9 (
        .clock(clock), .reset(reset9), .start(start9), .active(active9),
        .locations(loc9), .radii(rad9), .busy(busy9), .done(done9),
        .collision(coll9), .pair_count(count9)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] x0, input logic [31:0] y0,
                                 input logic [31:0] x1, input logic [31:0] y1,
                                 input logic [31:0] x2, input logic [31:0] y2,
                                 input logic [6:0] r0, input logic [6:0] r1,
                                 input logic [6:0] r2, input logic [2:0] act);
        loc3[0][0] = x0; loc3[0][1] = y0;
        loc3[1][0] = x1; loc3[1][1] = y1;
        loc3[2][0] = x2; loc3[2][1] = y2;
        rad3[0] = r0; rad3[1] = r1; rad3[2] = r2;
        active3 = act;
    endtask

    // Pulses start, then counts cycles to done; busy is sampled once per cycle
    // from the acceptance edge up to (not including) the done cycle.
    task automatic run_scan(input bit big, output int lat, output int busy_cycles);
        lat         = -1;
        busy_cycles = 0;
        if (big) start9 = 1'b1; else start3 = 1'b1;
        @(posedge clock); #1;
        start3 = 1'b0;
        start9 = 1'b0;
        if (big ? busy9 : busy3) busy_cycles++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            if (big ? done9 : done3) begin
                lat = k;
                break;
            end
            if (big ? busy9 : busy3) busy_cycles++;
        end
    endtask

    initial begin
        int lat, busy_cycles, done_pulses, first_done;
        bit early;

        reset3 = 1'b1; reset9 = 1'b1; start3 = 1'b0; start9 = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        for (int n = 0; n < 9; n++) begin
            loc9[n][0] = 32'(n * 100 * 65536);
            loc9[n][1] = 32'h0;
            rad9[n]    = 7'd5;
        end
        loc9[1][0] = 32'h0008_0000;
        loc9[5][0] = loc9[4][0];
        active9    = '1;

        exp3 = '0; exp3[0][1] = 1'b1; exp3[1][0] = 1'b1;
        exp9 = '0; exp9[0][1] = 1'b1; exp9[1][0] = 1'b1;
        exp9[4][5] = 1'b1; exp9[5][4] = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        reset3 = 1'b0; reset9 = 1'b0;
        checkOutput("reset busy3", busy3, 0);
        checkOutput("reset done3", done3, 0);
        checkOutput("reset coll3", coll3, 0);
        checkOutput("reset count3", count3, 0);
        checkOutput("reset busy9", busy9, 0);
        checkOutput("reset coll9", coll9, 0);

        $display("[TB] basic overlap scan");
        applyStimulus(0, 0, 32'h0008_0000, 0, 32'h0064_0000, 32'h0064_0000,
                      5, 5, 5, 3'b111);
        run_scan(0, lat, busy_cycles);
        checkOutput("basic latency", lat, 6);
        checkOutput("basic busy cycles", busy_cycles, 6);
        checkOutput("basic busy at done", busy3, 0);
        checkOutput("basic coll", coll3, exp3);
        checkOutput("basic count", count3, 1);
        @(posedge clock); #1;
        checkOutput("basic done width", done3, 0);
        checkOutput("basic coll held", coll3, exp3);

        $display("[TB] touching boundary");
        applyStimulus(0, 0, 32'(-6 * 65536), 0, 32'h0064_0000, 32'h0064_0000,
                      3, 3, 3, 3'b111);
        run_scan(0, lat, busy_cycles);
        checkOutput("touch exact coll", coll3, exp3);
        checkOutput("touch exact count", count3, 1);
        // 398639^2 >> 32 is still 36, 398640^2 >> 32 is 37.
        loc3[1][0] = 32'(-398639);
        run_scan(0, lat, busy_cycles);
        checkOutput("touch inner coll", coll3, exp3);
        checkOutput("touch inner count", count3, 1);
        loc3[1][0] = 32'(-398640);
        run_scan(0, lat, busy_cycles);
        checkOutput("touch outer coll", coll3, 0);
        checkOutput("touch outer count", count3, 0);

        $display("[TB] coordinate extremes");
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                      0, 0, 127, 127, 127, 3'b111);
        run_scan(0, lat, busy_cycles);
        checkOutput("extreme apart coll", coll3, 0);
        checkOutput("extreme apart count", count3, 0);
        loc3[0][0] = 32'h8000_0000; loc3[0][1] = 32'h8000_0000;
        run_scan(0, lat, busy_cycles);
        checkOutput("extreme same coll", coll3, exp3);
        checkOutput("extreme same count", count3, 1);

        $display("[TB] inactive sprite");
        applyStimulus(0, 0, 32'h0008_0000, 0, 32'h0064_0000, 32'h0064_0000,
                      5, 5, 5, 3'b101);
        run_scan(0, lat, busy_cycles);
        checkOutput("inactive coll", coll3, 0);
        checkOutput("inactive count", count3, 0);

        $display("[TB] snapshot and ignored start");
        applyStimulus(0, 0, 32'h0008_0000, 0, 32'h0064_0000, 32'h0064_0000,
                      5, 5, 5, 3'b111);
        start3 = 1'b1;
        @(posedge clock); #1;
        start3      = 1'b0;
        done_pulses = 0;
        first_done  = -1;
        early       = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clock); #1;
            if (e == 3) start3 = 1'b0;
            if (done3) begin
                done_pulses++;
                if (first_done < 0) first_done = e;
            end else if (first_done < 0 && (coll3 != 0 || count3 != 0)) begin
                early = 1'b1;
            end
            if (e == 2) begin
                loc3[2][0] = 32'h0008_0000;
                loc3[2][1] = 32'h0;
                loc3[0][0] = 32'h0064_0000;
                start3     = 1'b1;
            end
        end
        checkOutput("snapshot done pulses", done_pulses, 1);
        checkOutput("snapshot latency", first_done, 6);
        checkOutput("snapshot no early change", early, 0);
        checkOutput("snapshot coll", coll3, exp3);
        checkOutput("snapshot count", count3, 1);

        $display("[TB] nine sprites and reset abort");
        run_scan(1, lat, busy_cycles);
        checkOutput("nine latency", lat, 39);
        checkOutput("nine busy cycles", busy_cycles, 39);
        checkOutput("nine coll", coll9, exp9);
        checkOutput("nine count", count9, 2);
        start9 = 1'b1;
        @(posedge clock); #1;
        start9 = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset9 = 1'b1;
        @(posedge clock); #1;
        reset9 = 1'b0;
        checkOutput("abort busy", busy9, 0);
        checkOutput("abort done", done9, 0);
        checkOutput("abort coll", coll9, 0);
        checkOutput("abort count", count9, 0);
        done_pulses = 0;
        for (int e = 0; e < 45; e++) begin
            @(posedge clock); #1;
            if (done9) done_pulses++;
        end
        checkOutput("abort no done", done_pulses, 0);
        run_scan(1, lat, busy_cycles);
        checkOutput("restart latency", lat, 39);
        checkOutput("restart coll", coll9, exp9);
        checkOutput("restart count", count9, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
